// File: rtl/fetch_ip_gen.sv
// Fetch IP sequencer: flush > stall > BTB-taken > sequential, all outputs registered, 1-cycle next-EIP latency.
// Stall freezes fetch outputs; FETCH_BTB_PRED_EN enables taken-branch redirection from the BTB.
module fetch_ip_gen #(
  parameter logic [31:0] RESET_EIP = 32'hFFFFFFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EIP_target,
  input  logic [31:0] FIP_E_target,
  input  logic [31:0] FIP_O_target,
  input  logic        miss_hit,
  input  logic        adv,
  input  logic [3:0]  adv_len,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_EIP,
  output logic [31:0] EIP_fetch,
  output logic [31:0] FIP_E,
  output logic [31:0] FIP_O,
  output logic        fetch_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  typedef enum logic [1:0] {ST_RST, ST_RUN, ST_REDIR} state_t;
  state_t state;

  // Returns {FIP_E, FIP_O}; the line above the current one wraps within 28 bits.
  function automatic logic [63:0] fip_pair(input logic [31:0] eip);
    logic [27:0] line;
    logic [27:0] line_nxt;
    line     = eip[31:4];
    line_nxt = line + 28'd1;
    return line[0] ? {4'b0, line_nxt, 4'b0, line} : {4'b0, line, 4'b0, line_nxt};
  endfunction

  logic [3:0]  len_eff;
  logic [31:0] seq_eip;
  logic        run_adv;
  logic        take_hit;

  assign len_eff = (adv_len == 4'd0) ? 4'd1 : adv_len;
  assign seq_eip = EIP_fetch + {28'd0, len_eff};
  assign run_adv = (state == ST_RUN) && !stall && adv;

`ifdef FETCH_BTB_PRED_EN
  assign take_hit = miss_hit;
`else
  logic unused_btb;
  assign unused_btb = miss_hit;
  assign take_hit   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_RST;
      EIP_fetch      <= RESET_EIP;
      {FIP_E, FIP_O} <= fip_pair(RESET_EIP);
      fetch_valid    <= 1'b0;
      pred_taken     <= 1'b0;
      pred_target    <= 32'd0;
    end else if (flush) begin
      // Redirect wins over stall and any same-cycle advance.
      state          <= ST_REDIR;
      EIP_fetch      <= redirect_EIP;
      {FIP_E, FIP_O} <= fip_pair(redirect_EIP);
      fetch_valid    <= 1'b0;
      pred_taken     <= 1'b0;
    end else begin
      // RST and REDIR both last one cycle; stalled RUN stays in RUN.
      state       <= ST_RUN;
      fetch_valid <= 1'b1;
      pred_taken  <= 1'b0;
      if (run_adv) begin
        pred_taken <= take_hit;
        if (take_hit) begin
          EIP_fetch   <= EIP_target;
          FIP_E       <= FIP_E_target;
          FIP_O       <= FIP_O_target;
          pred_target <= EIP_target;
        end else begin
          EIP_fetch      <= seq_eip;
          {FIP_E, FIP_O} <= fip_pair(seq_eip);
          pred_target    <= seq_eip;
        end
      end
    end
  end

endmodule
